// File: rtl/fs_cap_mc.sv
// Multi-channel frame-sync capture: per-channel VS synchroniser, glitch filter,
// edge/level output, wrapping frame counter and lost-sync timeout.
module fs_cap_mc #(
    parameter int CH_NUM      = 4,
    parameter int SYNC_STAGES = 3,
    parameter int FILT_LEN    = 4,
    parameter int MODE        = 1,
    parameter int FCNT_W      = 16,
    parameter int TO_W        = 24,
    parameter int TIMEOUT     = 0
) (
    input  logic                     I_clk,
    input  logic                     I_rst,
    input  logic [CH_NUM-1:0]        I_vs,
    input  logic [CH_NUM-1:0]        I_ch_en,
    input  logic                     I_cnt_clr,
    output logic [CH_NUM-1:0]        O_fs_cap,
    output logic [CH_NUM*FCNT_W-1:0] O_fcnt,
    output logic [CH_NUM-1:0]        O_timeout
);

    localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    typedef logic [SYNC_STAGES-1:0] sync_t;

    (* ASYNC_REG = "TRUE" *) sync_t sync_q [CH_NUM];
    sync_t                          sync_d [CH_NUM];

    logic [CH_NUM-1:0] vs_f_q, vs_f_d;
    logic [CH_NUM-1:0] vs_f_dly_q, vs_f_dly_d;
    logic [CH_NUM-1:0] fs_cap_q, fs_cap_d;
    logic [CH_NUM-1:0] timeout_q, timeout_d;
    logic [CNT_W-1:0]  filt_cnt_q [CH_NUM];
    logic [CNT_W-1:0]  filt_cnt_d [CH_NUM];
    logic [FCNT_W-1:0] fcnt_q [CH_NUM];
    logic [FCNT_W-1:0] fcnt_d [CH_NUM];
    logic [TO_W-1:0]   to_cnt_q [CH_NUM];
    logic [TO_W-1:0]   to_cnt_d [CH_NUM];

    // Stage 1 is bit 0; the synchronised level leaves from the top bit.
    always_comb begin
        for (int i = 0; i < CH_NUM; i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], I_vs[i]};
        end
    end

    always_ff @(posedge I_clk) begin
        for (int i = 0; i < CH_NUM; i++) begin
            sync_q[i] <= sync_d[i];
        end
    end

    always_comb begin
        logic sync_out;
        logic rise;
        logic fall;
        logic active;
        vs_f_d     = vs_f_q;
        vs_f_dly_d = vs_f_q;
        fs_cap_d   = '0;
        timeout_d  = '0;
        filt_cnt_d = filt_cnt_q;
        fcnt_d     = fcnt_q;
        to_cnt_d   = to_cnt_q;
        for (int i = 0; i < CH_NUM; i++) begin
            sync_out = sync_q[i][SYNC_STAGES-1];
            // The filter runs regardless of enable so re-enabling cannot fake an edge.
            if (sync_out == vs_f_q[i]) begin
                filt_cnt_d[i] = '0;
            end else if (filt_cnt_q[i] == CNT_W'(FILT_LEN - 1)) begin
                vs_f_d[i]     = sync_out;
                filt_cnt_d[i] = '0;
            end else begin
                filt_cnt_d[i] = filt_cnt_q[i] + CNT_W'(1);
            end

            rise   = vs_f_q[i] & ~vs_f_dly_q[i];
            fall   = ~vs_f_q[i] & vs_f_dly_q[i];
            active = (MODE == 2) ? fall : (MODE == 3) ? (rise | fall) : rise;

            if (I_ch_en[i]) begin
                fs_cap_d[i] = (MODE == 0) ? vs_f_q[i] : active;
                if (active) begin
                    fcnt_d[i]   = fcnt_q[i] + FCNT_W'(1);
                    to_cnt_d[i] = '0;
                end else if (to_cnt_q[i] != TO_W'(TIMEOUT)) begin
                    to_cnt_d[i] = to_cnt_q[i] + TO_W'(1);
                end
            end else begin
                to_cnt_d[i] = '0;
            end

            if (I_cnt_clr) begin
                fcnt_d[i] = '0;
            end
            timeout_d[i] = (TIMEOUT != 0) && I_ch_en[i] && (to_cnt_d[i] == TO_W'(TIMEOUT));
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            vs_f_q     <= '0;
            vs_f_dly_q <= '0;
            fs_cap_q   <= '0;
            timeout_q  <= '0;
            for (int i = 0; i < CH_NUM; i++) begin
                filt_cnt_q[i] <= '0;
                fcnt_q[i]     <= '0;
                to_cnt_q[i]   <= '0;
            end
        end else begin
            vs_f_q     <= vs_f_d;
            vs_f_dly_q <= vs_f_dly_d;
            fs_cap_q   <= fs_cap_d;
            timeout_q  <= timeout_d;
            for (int i = 0; i < CH_NUM; i++) begin
                filt_cnt_q[i] <= filt_cnt_d[i];
                fcnt_q[i]     <= fcnt_d[i];
                to_cnt_q[i]   <= to_cnt_d[i];
            end
        end
    end

    always_comb begin
        O_fcnt = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            O_fcnt[i*FCNT_W +: FCNT_W] = fcnt_q[i];
        end
    end

    assign O_fs_cap  = fs_cap_q;
    assign O_timeout = timeout_q;

endmodule

// File: tb/tb_fs_cap_mc.sv
// Bench for fs_cap_mc: one instance per MODE driven by shared random VS traffic,
// checked every cycle against a window-based behavioural model.
module tb_fs_cap_mc;

    localparam int CH = 4;
    localparam int S  = 3;
    localparam int F  = 4;
    localparam int ND = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [CH-1:0]   vs;
    logic [CH-1:0]   ch_en;
    logic            cnt_clr;
    logic [CH-1:0]   fs_cap [ND];
    logic [CH*4-1:0] fcnt   [ND];
    logic [CH-1:0]   tout   [ND];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int TO = (g == 3) ? 0 : (30 + 10 * g);
        fs_cap_mc #(
            .CH_NUM(CH), .SYNC_STAGES(S), .FILT_LEN(F), .MODE(g),
            .FCNT_W(4), .TO_W(24), .TIMEOUT(TO)
        ) u_dut (
            .I_clk(clk), .I_rst(rst), .I_vs(vs), .I_ch_en(ch_en), .I_cnt_clr(cnt_clr),
            .O_fs_cap(fs_cap[g]), .O_fcnt(fcnt[g]), .O_timeout(tout[g])
        );
    end

    // Reference model state
    bit hist [CH][$];
    int ne        = 0;
    int since_rst = 0;
    bit m_vf  [CH];
    int m_chg [CH];
    int m_fc  [ND][CH];
    int m_to  [ND][CH];
    bit e_cap [ND][CH];
    bit e_to  [ND][CH];

    function automatic int to_of(int d);
        return (d == 3) ? 0 : 30 + 10 * d;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        for (int c = 0; c < CH; c++) hist[c].push_back(vs[c]);
        if (rst) begin
            since_rst = 0;
            for (int c = 0; c < CH; c++) begin
                m_vf[c]  = 0;
                m_chg[c] = 0;
                for (int d = 0; d < ND; d++) begin
                    m_fc[d][c] = 0; m_to[d][c] = 0; e_cap[d][c] = 0; e_to[d][c] = 0;
                end
            end
        end else begin
            since_rst++;
            for (int c = 0; c < CH; c++) begin
                for (int d = 0; d < ND; d++) begin
                    bit act;
                    int t;
                    act = (m_chg[c] == 1 && d != 2) || (m_chg[c] == 2 && d >= 2);
                    t   = to_of(d);
                    e_cap[d][c] = ch_en[c] ? ((d == 0) ? m_vf[c] : act) : 1'b0;
                    if (cnt_clr) m_fc[d][c] = 0;
                    else if (ch_en[c] && act) m_fc[d][c] = (m_fc[d][c] + 1) % 16;
                    if (!ch_en[c] || act) m_to[d][c] = 0;
                    else if (m_to[d][c] < t) m_to[d][c]++;
                    e_to[d][c] = (t > 0) && (m_to[d][c] == t);
                end
                // Level flips once the last F synchronised samples since reset all disagree.
                m_chg[c] = 0;
                if (since_rst >= F) begin
                    bit flip;
                    flip = 1;
                    for (int k = 0; k < F; k++) begin
                        int idx;
                        bit s;
                        idx = ne - S - k;
                        s = (idx >= 0) ? hist[c][idx] : 1'b0;
                        if (s == m_vf[c]) flip = 0;
                    end
                    if (flip) begin
                        m_vf[c]  = ~m_vf[c];
                        m_chg[c] = m_vf[c] ? 1 : 2;
                    end
                end
            end
        end
        ne++;
    endtask

    task automatic check_all();
        for (int d = 0; d < ND; d++) begin
            for (int c = 0; c < CH; c++) begin
                check_eq($sformatf("cap_m%0d_ch%0d", d, c), 32'(fs_cap[d][c]), 32'(e_cap[d][c]));
                check_eq($sformatf("fcnt_m%0d_ch%0d", d, c), 32'(fcnt[d][c*4 +: 4]), 32'(m_fc[d][c]));
                check_eq($sformatf("tout_m%0d_ch%0d", d, c), 32'(tout[d][c]), 32'(e_to[d][c]));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst = 1'b1; vs = '0; ch_en = '1; cnt_clr = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // First rise on ch0: pulse must occupy exactly the cycle after edge 7.
        vs[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (k == 6 || k == 8) check_eq("t1_no_pulse", 32'(fs_cap[1][0]), 32'd0);
            if (k == 7) begin
                check_eq("t1_pulse", 32'(fs_cap[1][0]), 32'd1);
                check_eq("t1_other_ch", 32'(fs_cap[1][3:1]), 32'd0);
            end
            if (k == 9) check_eq("t1_fcnt", 32'(fcnt[1][3:0]), 32'd1);
        end

        // Randomised traffic: busy, then sparse (timeouts), then busy again.
        for (int cyc = 0; cyc < 6000; cyc++) begin
            int p;
            p = (cyc >= 2500 && cyc < 5000) ? 300 : 5;
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, p - 1) == 0) vs[c] = ~vs[c];
            end
            if ($urandom_range(0, 99) == 0) ch_en[$urandom_range(0, CH - 1)] ^= 1'b1;
            if (ch_en != '1 && $urandom_range(0, 49) == 0) ch_en = '1;
            cnt_clr = ($urandom_range(0, 149) == 0);
            rst     = ($urandom_range(0, 999) == 0);
            tick();
        end

        // Reset in the middle of a held-high frame, then release.
        rst = 1'b0; cnt_clr = 1'b0; ch_en = '1; vs = '1;
        for (int i = 0; i < 20; i++) tick();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) tick();
        check_eq("t6_rst_cap", 32'(fs_cap[1]), 32'd0);
        check_eq("t6_rst_fcnt", 32'(fcnt[1]), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check_eq("t6_post_fcnt", 32'(fcnt[1]), 32'h1111);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
